// File: rtl/seg7_array.sv
// Multi-digit hex seven-segment driver with parallel and time-multiplexed
// outputs, per-digit enable, leading-zero suppression and blinking.
module seg7_array #(
  parameter int DIGITS    = 8,
  parameter int BLINK_DIV = 25000000,
  parameter int SCAN_DIV  = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_blank,
  output logic [7*DIGITS-1:0]   seg_par,
  output logic [DIGITS-1:0]     dp_n,
  output logic [6:0]            seg_scan,
  output logic                  dp_scan_n,
  output logic [DIGITS-1:0]     an_n
);

  localparam int BW = $clog2(BLINK_DIV);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  logic [4*DIGITS-1:0]     val_p0;
  logic [DIGITS-1:0]       dp_p0;
  logic [BW-1:0]           bcnt;
  logic                    blink_phase;
  logic [CW-1:0]           scnt;
  logic [SW-1:0]           sidx;
  logic [DIGITS:0]         lz_run;
  logic [DIGITS-1:0]       blank_c;
  logic [DIGITS-1:0][6:0]  seg_c;
  logic [DIGITS-1:0]       dpn_c;

  // ---- stage p0: captured value/dp and free-running blink/scan timebases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_p0      <= '0;
      dp_p0       <= '0;
      bcnt        <= '0;
      blink_phase <= 1'b0;
      scnt        <= '0;
      sidx        <= '0;
    end else begin
      if (load) begin
        val_p0 <= value;
        dp_p0  <= dp;
      end
      if (bcnt == BW'(BLINK_DIV - 1)) begin
        bcnt        <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
      if (scnt == CW'(SCAN_DIV - 1)) begin
        scnt <= '0;
        sidx <= (sidx == SW'(DIGITS - 1)) ? '0 : sidx + 1'b1;
      end else begin
        scnt <= scnt + 1'b1;
      end
    end
  end

  // lz_run[i] is set while digits DIGITS-1..i are all zero; digit 0 is exempt.
  always_comb begin
    lz_run         = '0;
    lz_run[DIGITS] = 1'b1;
    blank_c        = '0;
    seg_c          = '0;
    dpn_c          = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run[i]  = lz_run[i+1] && (val_p0[4*i +: 4] == 4'h0);
      blank_c[i] = !digit_en[i]
                 || (lz_blank && lz_run[i] && (i > 0))
                 || (blink_phase && blink_mask[i]);
      seg_c[i]   = blank_c[i] ? 7'h7F : hex7(val_p0[4*i +: 4]);
      dpn_c[i]   = blank_c[i] | ~dp_p0[i];
    end
  end

  // ---- stage p1: registered parallel and scan outputs, scan trio aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_par   <= '1;
      dp_n      <= '1;
      seg_scan  <= 7'h7F;
      dp_scan_n <= 1'b1;
      an_n      <= '1;
    end else begin
      seg_par   <= seg_c;
      dp_n      <= dpn_c;
      seg_scan  <= seg_c[sidx];
      dp_scan_n <= dpn_c[sidx];
      an_n      <= ~(DIGITS'(1) << sidx);
    end
  end

endmodule
